// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared class, flag, rounding encodings and format helpers for the FP multiplier
package fp_pkg;

    // Operand classes
    localparam logic [1:0] CLS_ZERO = 2'd0;
    localparam logic [1:0] CLS_NORM = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    // Bit positions inside the 5-bit flags word
    localparam int FLG_INV  = 4;
    localparam int FLG_OVF  = 3;
    localparam int FLG_UNF  = 2;
    localparam int FLG_INX  = 1;
    localparam int FLG_ZERO = 0;

    // Rounding modes
    localparam logic RND_RNE   = 1'b0;
    localparam logic RND_TRUNC = 1'b1;

    // Product outcome decided purely from the operand classes
    localparam logic [1:0] SPC_NONE = 2'd0;
    localparam logic [1:0] SPC_NAN  = 2'd1;
    localparam logic [1:0] SPC_INF  = 2'd2;
    localparam logic [1:0] SPC_ZERO = 2'd3;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Quiet NaN: sign 0, exponent all ones, only the fraction MSB set
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    // Largest finite magnitude (no sign bit)
    function automatic logic [63:0] fp_max_finite(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd2) << man_w) | ((64'd1 << man_w) - 64'd1);
    endfunction

    // NaN beats Inf beats Zero; Inf x Zero is invalid
    function automatic logic [1:0] fp_special(input logic [1:0] ca, input logic [1:0] cb);
        if (ca == CLS_NAN || cb == CLS_NAN ||
            (ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF))
            return SPC_NAN;
        else if (ca == CLS_INF || cb == CLS_INF)
            return SPC_INF;
        else if (ca == CLS_ZERO || cb == CLS_ZERO)
            return SPC_ZERO;
        else
            return SPC_NONE;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - per-operand field split, classification and flush-to-zero
module fp_unpack
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic [EXP_W+MAN_W:0] x,
    output logic                 sign,
    output logic [EXP_W-1:0]     exp_f,
    output logic [MAN_W:0]       man,
    output logic [1:0]           cls
);

    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;

    // Split fields, classify, and flush zero/subnormal operands to a clean zero
    always_comb begin
        sign  = x[EXP_W+MAN_W];
        e     = x[EXP_W+MAN_W-1 -: EXP_W];
        f     = x[MAN_W-1:0];
        exp_f = e;
        man   = {1'b1, f};
        cls   = CLS_NORM;
        if (e == '1) begin
            cls = (f != '0) ? CLS_NAN : CLS_INF;
        end else if (e == '0) begin
            cls   = CLS_ZERO;
            exp_f = '0;
            man   = '0;
        end
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - three-stage parametrised floating-point multiplier with valid/ready
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 rnd_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [4:0]           flags
);

    localparam int DWIDTH = 1 + EXP_W + MAN_W;
    localparam int EW     = EXP_W + 2;
    localparam int PW     = 2 * MAN_W + 2;

    localparam logic [EW-1:0]     BIAS    = EW'(fp_bias(EXP_W));
    localparam logic [EW-1:0]     EXP_TOP = EW'((1 << EXP_W) - 1);
    localparam logic [DWIDTH-1:0] QNAN    = DWIDTH'(fp_qnan(EXP_W, MAN_W));
    localparam logic [DWIDTH-2:0] MAXF    = (DWIDTH-1)'(fp_max_finite(EXP_W, MAN_W));
    localparam logic [DWIDTH-2:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

    logic stall, adv, accept;
    logic rdy_q, rdy_d;

    logic              ua_sign, ub_sign;
    logic [EXP_W-1:0]  ua_exp, ub_exp;
    logic [MAN_W:0]    ua_man, ub_man;
    logic [1:0]        ua_cls, ub_cls;

    logic              s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s1_rnd_q, s1_rnd_d;
    logic [EW-1:0]     s1_exp_q, s1_exp_d;
    logic [MAN_W:0]    s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
    logic [1:0]        s1_spc_q, s1_spc_d;

    logic              s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d, s2_rnd_q, s2_rnd_d;
    logic [EW-1:0]     s2_exp_q, s2_exp_d;
    logic [PW-1:0]     s2_prod_q, s2_prod_d;
    logic [1:0]        s2_spc_q, s2_spc_d;

    logic              out_valid_q, out_valid_d;
    logic [DWIDTH-1:0] result_q, result_d;
    logic [4:0]        flags_q, flags_d;

    logic              top, guard, sticky, rnd_up;
    logic [PW-1:0]     shifted;
    logic [MAN_W:0]    kept;
    logic [MAN_W+1:0]  man_r;
    logic [MAN_W-1:0]  frac_r;
    logic [EW-1:0]     exp_r;
    logic [DWIDTH-1:0] pack_res;
    logic [4:0]        pack_flg;

    assign stall     = out_valid_q & ~out_ready;
    assign adv       = ~stall;
    assign in_ready  = rst & rdy_q & ~stall;
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .x(a), .sign(ua_sign), .exp_f(ua_exp), .man(ua_man), .cls(ua_cls)
    );

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .x(b), .sign(ub_sign), .exp_f(ub_exp), .man(ub_man), .cls(ub_cls)
    );

    // Stage 1/2 next state: classify and sum exponents, then multiply mantissas; hold on stall
    always_comb begin
        rdy_d      = 1'b1;
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_rnd_d   = s1_rnd_q;
        s1_exp_d   = s1_exp_q;
        s1_ma_d    = s1_ma_q;
        s1_mb_d    = s1_mb_q;
        s1_spc_d   = s1_spc_q;
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_rnd_d   = s2_rnd_q;
        s2_exp_d   = s2_exp_q;
        s2_prod_d  = s2_prod_q;
        s2_spc_d   = s2_spc_q;
        if (adv) begin
            s1_valid_d = accept;
            s1_sign_d  = ua_sign ^ ub_sign;
            s1_rnd_d   = rnd_mode;
            s1_exp_d   = {2'b00, ua_exp} + {2'b00, ub_exp} - BIAS;
            s1_ma_d    = ua_man;
            s1_mb_d    = ub_man;
            s1_spc_d   = fp_special(ua_cls, ub_cls);
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_rnd_d   = s1_rnd_q;
            s2_exp_d   = s1_exp_q;
            s2_prod_d  = PW'(s1_ma_q) * PW'(s1_mb_q);
            s2_spc_d   = s1_spc_q;
        end
    end

    // Stage 3 datapath: normalise, round, pack, then override with special results
    always_comb begin
        top     = s2_prod_q[PW-1];
        shifted = top ? s2_prod_q : {s2_prod_q[PW-2:0], 1'b0};
        kept    = shifted[PW-1 -: MAN_W+1];
        guard   = shifted[MAN_W];
        sticky  = |shifted[MAN_W-1:0];
        rnd_up  = (s2_rnd_q == RND_RNE) & guard & (sticky | kept[0]);
        man_r   = {1'b0, kept} + {{(MAN_W+1){1'b0}}, rnd_up};
        // A rounding carry leaves 10.00..0; renormalise by one more place
        frac_r  = man_r[MAN_W+1] ? man_r[MAN_W:1] : man_r[MAN_W-1:0];
        exp_r   = s2_exp_q + {{(EW-1){1'b0}}, top} + {{(EW-1){1'b0}}, man_r[MAN_W+1]};

        pack_res = {s2_sign_q, exp_r[EXP_W-1:0], frac_r};
        pack_flg = '0;
        pack_flg[FLG_INX] = guard | sticky;

        if (!exp_r[EW-1] && exp_r >= EXP_TOP) begin
            pack_res = {s2_sign_q, (s2_rnd_q == RND_TRUNC) ? MAXF : INF_MAG};
            pack_flg[FLG_OVF] = 1'b1;
            pack_flg[FLG_INX] = 1'b1;
        end else if (exp_r[EW-1] || exp_r == '0) begin
            pack_res = {s2_sign_q, {(DWIDTH-1){1'b0}}};
            pack_flg[FLG_UNF]  = 1'b1;
            pack_flg[FLG_INX]  = 1'b1;
            pack_flg[FLG_ZERO] = 1'b1;
        end

        case (s2_spc_q)
            SPC_NAN: begin
                pack_res = QNAN;
                pack_flg = '0;
                pack_flg[FLG_INV] = 1'b1;
            end
            SPC_INF: begin
                pack_res = {s2_sign_q, INF_MAG};
                pack_flg = '0;
            end
            SPC_ZERO: begin
                pack_res = {s2_sign_q, {(DWIDTH-1){1'b0}}};
                pack_flg = '0;
                pack_flg[FLG_ZERO] = 1'b1;
            end
            default: ;
        endcase
    end

    // Output register next state: result/flags only change when a valid item moves in
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (adv) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                result_d = pack_res;
                flags_d  = pack_flg;
            end
        end
    end

    // Pipeline registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdy_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_rnd_q    <= 1'b0;
            s1_exp_q    <= '0;
            s1_ma_q     <= '0;
            s1_mb_q     <= '0;
            s1_spc_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_rnd_q    <= 1'b0;
            s2_exp_q    <= '0;
            s2_prod_q   <= '0;
            s2_spc_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            rdy_q       <= rdy_d;
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_rnd_q    <= s1_rnd_d;
            s1_exp_q    <= s1_exp_d;
            s1_ma_q     <= s1_ma_d;
            s1_mb_q     <= s1_mb_d;
            s1_spc_q    <= s1_spc_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_rnd_q    <= s2_rnd_d;
            s2_exp_q    <= s2_exp_d;
            s2_prod_q   <= s2_prod_d;
            s2_spc_q    <= s2_spc_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - scoreboard bench for fp_mult_pipe (FP16 and FP32 instances)
module tb_fp_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, rnd_mode, out_valid, out_ready;
    logic [15:0] a, b, result;
    logic [4:0]  flags;

    logic        in_valid32, in_ready32, rnd32, out_valid32, out_ready32;
    logic [31:0] a32, b32, result32;
    logic [4:0]  flags32;

    fp_mult_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .rnd_mode(rnd_mode), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags)
    );

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .rnd_mode(rnd32), .out_valid(out_valid32),
        .out_ready(out_ready32), .result(result32), .flags(flags32)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        r;
        logic [15:0] res;
        logic [4:0]  flg;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [4:0]  flg;
        int          cyc;
    } sb_t;

    vec_t        vecs [15];
    sb_t         sb [$];
    sb_t         mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [15:0] cur_res;
    logic [4:0]  cur_flg;
    bit          chk_lat = 1'b0;
    bit          chk_rdy = 1'b0;
    bit          hold_v  = 1'b0;
    logic [15:0] hold_res;
    logic [4:0]  hold_flg;
    logic [7:0]  pat = 8'b0110_1001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on accept, pop and compare on output transfer, watch stall hold
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            hold_v = 1'b0;
        end else begin
            if (in_valid && in_ready)
                sb.push_back('{cur_res, cur_flg, cyc});
            if (chk_rdy)
                check("in_ready_vs_stall", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (hold_v && out_valid) begin
                check("hold_result", {16'd0, result}, {16'd0, hold_res});
                check("hold_flags", {27'd0, flags}, {27'd0, hold_flg});
            end
            hold_v   = out_valid && !out_ready;
            hold_res = result;
            hold_flg = flags;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_output", {31'd0, out_valid}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", {16'd0, result}, {16'd0, mon_e.res});
                    check("flags", {27'd0, flags}, {27'd0, mon_e.flg});
                    if (chk_lat)
                        check("latency", cyc - mon_e.cyc, 32'd3);
                end
            end
        end
    end

    // Drive vecs[start..start+n-1] (wrapping), optionally with the out_ready pattern
    task automatic run_stream(input int start, input int n, input bit use_pat);
        int i = 0;
        int k = 0;
        bit acc;
        while ((i < n || sb.size() > 0) && k < 400) begin
            out_ready = use_pat ? pat[k % 8] : 1'b1;
            in_valid  = (i < n);
            if (i < n) begin
                a        = vecs[(start + i) % 15].a;
                b        = vecs[(start + i) % 15].b;
                rnd_mode = vecs[(start + i) % 15].r;
                cur_res  = vecs[(start + i) % 15].res;
                cur_flg  = vecs[(start + i) % 15].flg;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", i, n);
        check("stream_drained", sb.size(), 32'd0);
    endtask

    task automatic run32(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic [4:0] ef);
        int w = 0;
        a32 = x;
        b32 = y;
        in_valid32 = 1'b1;
        @(negedge clk);
        check("fp32_in_ready", {31'd0, in_ready32}, 32'd1);
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        while (!out_valid32 && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("fp32_latency", w, 32'd3);
        check("fp32_result", result32, er);
        check("fp32_flags", {27'd0, flags32}, {27'd0, ef});
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h1987, 5'b00010};
        vecs[1]  = '{16'hE37B, 16'h1AB4, 1'b0, 16'hC245, 5'b00010};
        vecs[2]  = '{16'hABCD, 16'h9876, 1'b0, 16'h085A, 5'b00010};
        vecs[3]  = '{16'hE37B, 16'h1AB4, 1'b1, 16'hC244, 5'b00010};
        vecs[4]  = '{16'hABCD, 16'h9876, 1'b1, 16'h0859, 5'b00010};
        vecs[5]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h3C00, 5'b00000};
        vecs[6]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 5'b01010};
        vecs[7]  = '{16'h7BFF, 16'h7BFF, 1'b1, 16'h7BFF, 5'b01010};
        vecs[8]  = '{16'h7C00, 16'h0000, 1'b0, 16'h7E00, 5'b10000};
        vecs[9]  = '{16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 5'b00000};
        vecs[10] = '{16'h0400, 16'h8400, 1'b0, 16'h8000, 5'b00111};
        vecs[11] = '{16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 5'b10000};
        vecs[12] = '{16'h8000, 16'h3C00, 1'b0, 16'h8000, 5'b00001};
        vecs[13] = '{16'h0001, 16'h3C00, 1'b0, 16'h0000, 5'b00001};
        vecs[14] = '{16'h7C00, 16'hFC00, 1'b0, 16'hFC00, 5'b00000};

        rst = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; rnd_mode = 1'b0; out_ready = 1'b1;
        in_valid32 = 1'b0; a32 = '0; b32 = '0; rnd32 = 1'b0; out_ready32 = 1'b1;
        cur_res = '0; cur_flg = '0;

        // Reset state and in_ready rising one cycle after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_flags", {27'd0, flags}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("release_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready_high", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back directed vectors with exact latency, then all specials
        chk_lat = 1'b1;
        run_stream(0, 3, 1'b0);
        run_stream(3, 12, 1'b0);
        chk_lat = 1'b0;

        // Back-pressure pattern: in_ready tracks stall, order and hold preserved
        chk_rdy = 1'b1;
        run_stream(0, 8, 1'b1);
        run_stream(8, 7, 1'b1);
        chk_rdy = 1'b0;

        // Reset with two operations in flight
        a = vecs[0].a; b = vecs[0].b; rnd_mode = vecs[0].r;
        cur_res = vecs[0].res; cur_flg = vecs[0].flg; in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = vecs[5].a; b = vecs[5].b; rnd_mode = vecs[5].r;
        cur_res = vecs[5].res; cur_flg = vecs[5].flg;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("inflight_before_rst", sb.size(), 32'd2);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", {16'd0, result}, 32'd0);
        check("midrst_flags", {27'd0, flags}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_release_low", {31'd0, in_ready}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk_lat = 1'b1;
        run_stream(5, 3, 1'b0);
        chk_lat = 1'b0;

        // FP32 instance
        run32(32'h3F800000, 32'h40000000, 32'h40000000, 5'b00000);
        run32(32'h3FC00000, 32'h3FC00000, 32'h40100000, 5'b00000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
